// File: rtl/shift_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : shift_pkg                                                |
// | Description : Shared encodings for the iterative shifter: shift-mode   |
// |               codes presented on the mode port and the controller      |
// |               state type.                                              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package shift_pkg;

  // Shift-mode encodings as seen on the mode input.
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : shift_step                                               |
// | Description : Single combinational shift stage. Shifts data by a       |
// |               small amount (0..STEP) in one of four modes. Used once  |
// |               per clock by iter_shifter to build a long shift out of   |
// |               short ones.                                              |
// | Ports       : data      in  WIDTH  value to shift                      |
// |               amount    in  KW     shift distance, 0..STEP             |
// |               mode      in  2      SLL / SRL / SRA / ROL               |
// |               fill_sign in  1      fill bit used for SRA               |
// |               shifted   out WIDTH  shifted value                       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    amount,
  input  logic [1:0]       mode,
  input  logic             fill_sign,
  output logic [WIDTH-1:0] shifted
);

  logic               fill;
  logic [2*WIDTH-1:0] right_ext;
  logic [2*WIDTH-1:0] rot_ext;

  // Right shifts run on a double-width word whose upper half holds the fill
  // bit, so SRL and SRA share one shifter. The fill comes from the sign
  // latched at the start of the operation, not from the current word, which
  // keeps multi-step SRA identical to a single arithmetic shift.
  assign fill      = (mode == MODE_SRA) && fill_sign;
  assign right_ext = {{WIDTH{fill}}, data} >> amount;

  // Rotate-left: the upper half of the shifted duplicated word.
  assign rot_ext   = {data, data} << amount;

  always_comb begin
    shifted = data;
    case (mode)
      MODE_SLL: shifted = data << amount;
      MODE_SRL: shifted = right_ext[WIDTH-1:0];
      MODE_SRA: shifted = right_ext[WIDTH-1:0];
      MODE_ROL: shifted = rot_ext[2*WIDTH-1:WIDTH];
      default:  shifted = data;
    endcase
  end

endmodule : shift_step
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : iter_shifter                                             |
// | Description : Multi-cycle variable shifter (SLL/SRL/SRA/ROL). Shifts   |
// |               at most STEP bits per clock under a start/done           |
// |               handshake.                                               |
// | Ports       : clock        in  1      rising-edge clock                |
// |               reset_n      in  1      asynchronous active-low reset    |
// |               start        in  1      request, taken only when ready   |
// |               mode         in  2      00 SLL 01 SRL 10 SRA 11 ROL      |
// |               shamt        in  SHW    shift amount 0..WIDTH-1          |
// |               data_operand in  WIDTH  value to shift                   |
// |               ready        out 1      idle, able to accept start       |
// |               busy         out 1      shifting                         |
// |               done         out 1      one-cycle result-valid pulse     |
// |               result       out WIDTH  working / final value            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data_operand,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int             KW       = $clog2(STEP + 1);
  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);
  localparam logic [KW-1:0]  STEP_K   = KW'(STEP);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   rem;
  logic [1:0]       mode_q;
  logic             sign_q;
  logic             accept;
  logic             last_step;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] stepped;

  assign accept    = (state == IDLE) && start;

  // When no more than STEP bits remain this is the final step; the
  // remainder then fits in the step-amount width.
  assign last_step = (rem <= STEP_AMT);
  assign k         = last_step ? KW'(rem) : STEP_K;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data      (work),
    .amount    (k),
    .mode      (mode_q),
    .fill_sign (sign_q),
    .shifted   (stepped)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero-length shift skips SHIFT entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands are captured on the accepting edge only, then the
  // work register advances by one stage per SHIFT cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work   <= '0;
      rem    <= '0;
      mode_q <= MODE_SLL;
      sign_q <= 1'b0;
    end else if (accept) begin
      work   <= data_operand;
      rem    <= shamt;
      mode_q <= mode;
      sign_q <= data_operand[WIDTH-1];
    end else if (state == SHIFT) begin
      work   <= stepped;
      rem    <= rem - SHW'(k);
    end
  end

  assign ready  = (state == IDLE);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign result = work;

endmodule : iter_shifter
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_iter_shifter                                          |
// | Description : Scoreboard bench for iter_shifter. Three instances with  |
// |               STEP = 1, 4, 16 share one stimulus stream; each has its  |
// |               own expectation queue drained by a monitor on done.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_iter_shifter;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          neg;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic [31:0] data_operand;

  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic [31:0] res [3];

  exp_t sb [3][$];
  int   tests   = 0;
  int   fails   = 0;
  int   neg_cnt = 0;
  int   tag     = 0;

  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clock(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .shamt(shamt), .data_operand(data_operand),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .result(res[0]));

  iter_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clock(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .shamt(shamt), .data_operand(data_operand),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .result(res[1]));

  iter_shifter #(.WIDTH(32), .STEP(16)) u_s16 (
    .clock(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .shamt(shamt), .data_operand(data_operand),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .result(res[2]));

  function automatic int step_of(input int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  // Cycles from the accepting edge until done is seen (done is sampled in
  // the L-th cycle after the accepting edge).
  function automatic int lat(input int sh, input int st);
    if (sh == 0) return 1;
    return 1 + (sh + st - 1) / st;
  endfunction

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d,
                                        input int sh);
    logic [31:0] r;
    case (m)
      MODE_SLL: r = d << sh;
      MODE_SRL: r = d >> sh;
      MODE_SRA: r = $signed(d) >>> sh;
      default:  r = (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
    endcase
    return r;
  endfunction

  task automatic check(input string nm, input int d, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s step%0d: got %0h expected %0h", nm, step_of(d), got, exp);
    end
  endtask

  // Monitor: each falling edge, check the one-hot status and pop the
  // scoreboard on done, comparing both result and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    for (int d = 0; d < 3; d++) begin
      check("onehot", d, 64'($countones({rdy[d], bsy[d], dn[d]})), 64'd1);
      if (dn[d] === 1'b1) begin
        if (sb[d].size() == 0) begin
          check("unexpected_done", d, 64'd1, 64'd0);
        end else begin
          e = sb[d].pop_front();
          check($sformatf("result_tag%0d", e.tag), d, 64'(res[d]), 64'(e.res));
          check($sformatf("latency_tag%0d", e.tag), d, 64'(neg_cnt), 64'(e.neg));
        end
      end
    end
  end

  task automatic wait_all_ready();
    int waited = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1] && rdy[2]) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("ready_timeout", 0, 64'd0, 64'd1);
  endtask

  // Issue one request on the falling edge; the following rising edge is the
  // accepting edge. Operands are scrambled straight after it.
  task automatic issue(input logic [1:0] m, input int sh, input logic [31:0] d,
                       input logic [31:0] exp_res, input bit track);
    wait_all_ready();
    #1;
    start        = 1'b1;
    mode         = m;
    shamt        = 5'(sh);
    data_operand = d;
    tag++;
    if (track) begin
      for (int i = 0; i < 3; i++) begin
        sb[i].push_back('{exp_res, neg_cnt + lat(sh, step_of(i)), tag});
      end
    end
    @(posedge clk);
    #1;
    start        = 1'b0;
    mode         = 2'($urandom);
    shamt        = 5'($urandom);
    data_operand = $urandom;
  endtask

  initial begin
    logic [31:0] d;
    reset_n      = 1'b0;
    start        = 1'b0;
    mode         = MODE_SLL;
    shamt        = '0;
    data_operand = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_ready",  i, 64'(rdy[i]), 64'd1);
      check("reset_busy",   i, 64'(bsy[i]), 64'd0);
      check("reset_done",   i, 64'(dn[i]),  64'd0);
      check("reset_result", i, 64'(res[i]), 64'd0);
    end
    #1 reset_n = 1'b1;

    // Directed vectors.
    issue(MODE_SLL,  4, 32'h0000_0001, 32'h0000_0010, 1'b1);
    issue(MODE_SRA, 31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(MODE_SRL, 31, 32'h8000_0000, 32'h0000_0001, 1'b1);
    issue(MODE_ROL,  5, 32'h8000_0001, 32'h0000_0030, 1'b1);
    issue(MODE_SLL,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    issue(MODE_SRA,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    issue(MODE_SRA,  4, 32'h7000_0000, 32'h0700_0000, 1'b1);
    issue(MODE_SRA,  8, 32'hF000_0000, 32'hFFF0_0000, 1'b1);
    issue(MODE_ROL, 16, 32'h1234_5678, 32'h5678_1234, 1'b1);
    issue(MODE_SLL, 31, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(MODE_SRL, 17, 32'h1234_5678, 32'h0000_091A, 1'b1);

    // Start while busy is ignored: a second request lands on edge E0+2.
    issue(MODE_SRL, 28, 32'hF000_0000, 32'h0000_000F, 1'b1);
    @(posedge clk);
    #1;
    start        = 1'b1;
    mode         = MODE_SLL;
    shamt        = 5'd3;
    data_operand = 32'h0000_1234;
    @(posedge clk);
    #1 start = 1'b0;

    // Reset in the middle of an operation: no done, state cleared.
    issue(MODE_SLL, 20, 32'h0000_0001, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("midreset_ready",  i, 64'(rdy[i]), 64'd1);
      check("midreset_busy",   i, 64'(bsy[i]), 64'd0);
      check("midreset_done",   i, 64'(dn[i]),  64'd0);
      check("midreset_result", i, 64'(res[i]), 64'd0);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    issue(MODE_SLL, 1, 32'h0000_0001, 32'h0000_0002, 1'b1);

    // Sweep every mode and shift amount.
    for (int m = 0; m < 4; m++) begin
      for (int sh = 0; sh < 32; sh++) begin
        d = $urandom;
        if (sh % 2 == 1) d[31] = 1'b1;
        issue(2'(m), sh, d, model(2'(m), d, sh), 1'b1);
      end
    end

    wait_all_ready();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("missing_done", i, 64'(sb[i].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_iter_shifter
`default_nettype wire
